reel_judge: RTL and testbench

REEL_JUDGE -- requirements
Module: reel_judge

---
 rtl/win_lose_pkg.sv | 29 ++
 rtl/reel_stable_det.sv | 38 +++
 rtl/reel_judge.sv | 156 +++++++++++++++
 tb/tb_reel_judge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/win_lose_pkg.sv
// rtl/win_lose_pkg.sv - shared types and constants for the reel judge
// FSM states, reel digit type, payout values and the three-reel scoring rule.
package win_lose_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SPIN   = 2'd1,
        ST_JUDGE  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t     MAX_DIGIT   = 4'd9;
    localparam logic [1:0] PAY_JACKPOT = 2'd3;
    localparam logic [1:0] PAY_PAIR    = 2'd1;
    localparam logic [1:0] PAY_NONE    = 2'd0;

    function automatic logic [1:0] judge_payout(input digit_t a, input digit_t b, input digit_t c);
        if ((a == b) && (b == c)) begin
            return PAY_JACKPOT;
        end else if ((a == b) || (b == c) || (a == c)) begin
            return PAY_PAIR;
        end else begin
            return PAY_NONE;
        end
    endfunction

endpackage

// File: rtl/reel_stable_det.sv
// rtl/reel_stable_det.sv - per-reel stop detector
// Counts consecutive cycles of an unchanged legal digit, saturating at STABLE_CYCLES.
module reel_stable_det
    import win_lose_pkg::*;
#(
    parameter logic [15:0] STABLE_CYCLES = 16'd50000
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_clear,
    input  digit_t i_digit,
    output logic   o_stopped
);

    digit_t      r_prev;
    logic [15:0] r_cnt;
    logic        w_same;

    // An out-of-range digit (wrap transient) never counts toward stability.
    assign w_same = (i_digit == r_prev) && (i_digit <= MAX_DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_prev <= i_digit;
            if (i_clear || !w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != STABLE_CYCLES) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_stopped = (r_cnt == STABLE_CYCLES);

endmodule

// File: rtl/reel_judge.sv
// rtl/reel_judge.sv - slot reel judge: spin, wait for reels to stop, score, pay
// Optional spin timeout enabled by defining REEL_JUDGE_TIMEOUT_EN.
module reel_judge
    import win_lose_pkg::*;
#(
    parameter logic [15:0] STABLE_CYCLES = 16'd50000,
    parameter logic [7:0]  INIT_CREDITS  = 8'd10,
    parameter logic [31:0] SPIN_TIMEOUT  = 32'd5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    output logic       busy,
    output logic       result_valid,
    output logic       win,
    output logic       lose,
    output logic [1:0] payout,
    output logic [7:0] credits,
    output logic       timeout
);

    state_t     r_state;
    logic       r_busy;
    logic       r_result_valid;
    logic       r_win;
    logic       r_lose;
    logic [1:0] r_payout;
    logic [7:0] r_credits;
    digit_t     r_d1;
    digit_t     r_d2;
    digit_t     r_d3;

    logic [2:0] w_stopped;
    logic       w_clear;
    logic       w_all_stopped;
    logic [1:0] w_pay;
    logic [8:0] w_sum;
    logic [7:0] w_credits_paid;

    // Counters are held clear outside SPIN, so they start from zero on SPIN entry.
    assign w_clear = (r_state != ST_SPIN);

    reel_stable_det #(.STABLE_CYCLES(STABLE_CYCLES)) u_reel1 (
        .clk(clk), .rst(rst), .i_clear(w_clear), .i_digit(digit1), .o_stopped(w_stopped[0])
    );
    reel_stable_det #(.STABLE_CYCLES(STABLE_CYCLES)) u_reel2 (
        .clk(clk), .rst(rst), .i_clear(w_clear), .i_digit(digit2), .o_stopped(w_stopped[1])
    );
    reel_stable_det #(.STABLE_CYCLES(STABLE_CYCLES)) u_reel3 (
        .clk(clk), .rst(rst), .i_clear(w_clear), .i_digit(digit3), .o_stopped(w_stopped[2])
    );

    assign w_all_stopped  = &w_stopped;
    assign w_pay          = judge_payout(r_d1, r_d2, r_d3);
    assign w_sum          = {1'b0, r_credits} + {7'd0, w_pay};
    assign w_credits_paid = w_sum[8] ? 8'hFF : w_sum[7:0];

`ifdef REEL_JUDGE_TIMEOUT_EN
    logic [31:0] r_tcnt;
    logic        r_timeout;
    logic        w_spin_timeout;

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SPIN)) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    // Fires during the SPIN_TIMEOUT-th SPIN cycle.
    assign w_spin_timeout = (r_state == ST_SPIN) && (r_tcnt == SPIN_TIMEOUT - 32'd1);
    assign timeout        = r_timeout;
`else
    // SPIN_TIMEOUT is referenced only to keep the parameter list uniform across builds.
    assign timeout = 1'b0 && (SPIN_TIMEOUT == 32'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_win          <= 1'b0;
            r_lose         <= 1'b0;
            r_payout       <= PAY_NONE;
            r_credits      <= INIT_CREDITS;
            r_d1           <= '0;
            r_d2           <= '0;
            r_d3           <= '0;
`ifdef REEL_JUDGE_TIMEOUT_EN
            r_timeout      <= 1'b0;
`endif
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (r_credits != 8'd0)) begin
                        r_state   <= ST_SPIN;
                        r_busy    <= 1'b1;
                        r_credits <= r_credits - 8'd1;
                    end
                end
                ST_SPIN: begin
                    // A stop in the same cycle as the timeout takes priority.
                    if (w_all_stopped) begin
                        r_state <= ST_JUDGE;
                        r_d1    <= digit1;
                        r_d2    <= digit2;
                        r_d3    <= digit3;
                    end
`ifdef REEL_JUDGE_TIMEOUT_EN
                    else if (w_spin_timeout) begin
                        r_state        <= ST_REPORT;
                        r_result_valid <= 1'b1;
                        r_win          <= 1'b0;
                        r_lose         <= 1'b1;
                        r_payout       <= PAY_NONE;
                        r_timeout      <= 1'b1;
                    end
`endif
                end
                ST_JUDGE: begin
                    r_state        <= ST_REPORT;
                    r_result_valid <= 1'b1;
                    r_win          <= (w_pay != PAY_NONE);
                    r_lose         <= (w_pay == PAY_NONE);
                    r_payout       <= w_pay;
                    r_credits      <= w_credits_paid;
`ifdef REEL_JUDGE_TIMEOUT_EN
                    r_timeout      <= 1'b0;
`endif
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign win          = r_win;
    assign lose         = r_lose;
    assign payout       = r_payout;
    assign credits      = r_credits;

endmodule

// File: tb/tb_reel_judge.sv
// tb/tb_reel_judge.sv - directed self-checking bench for reel_judge
// STABLE_CYCLES=4, INIT_CREDITS=2, SPIN_TIMEOUT=40; outputs sampled on the falling edge.
module tb_reel_judge;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       busy;
    logic       result_valid;
    logic       win;
    logic       lose;
    logic [1:0] payout;
    logic [7:0] credits;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    reel_judge #(
        .STABLE_CYCLES(16'd4),
        .INIT_CREDITS (8'd2),
        .SPIN_TIMEOUT (32'd40)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .busy        (busy),
        .result_valid(result_valid),
        .win         (win),
        .lose        (lose),
        .payout      (payout),
        .credits     (credits),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic spin_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_rv(input int max_cycles, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!result_valid && (n < max_cycles));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int n;
    bit seen_busy;
    bit seen_rv;

    initial begin
        start  = 1'b0;
        digit1 = 4'd7;
        digit2 = 4'd7;
        digit3 = 4'd7;
        rst    = 1'b0;
        tick();
        apply_reset();

        chk("reset_busy", busy, 0);
        chk("reset_rv", result_valid, 0);
        chk("reset_win", win, 0);
        chk("reset_lose", lose, 0);
        chk("reset_payout", payout, 0);
        chk("reset_credits", credits, 2);
        chk("reset_timeout", timeout, 0);

        // Jackpot 7,7,7
        spin_start();
        chk("jp_busy", busy, 1);
        chk("jp_credits_spent", credits, 1);
        wait_rv(20, n);
        chk("jp_latency", n, 6);
        chk("jp_win", win, 1);
        chk("jp_lose", lose, 0);
        chk("jp_payout", payout, 3);
        chk("jp_credits", credits, 4);
        tick();
        chk("jp_rv_pulse", result_valid, 0);
        chk("jp_idle_busy", busy, 0);
        chk("jp_win_held", win, 1);

        // Pair 3,3,5
        digit1 = 4'd3; digit2 = 4'd3; digit3 = 4'd5;
        spin_start();
        chk("pair_credits_spent", credits, 3);
        wait_rv(20, n);
        chk("pair_latency", n, 6);
        chk("pair_win", win, 1);
        chk("pair_payout", payout, 1);
        chk("pair_credits", credits, 4);
        tick();

        // All different 1,2,9
        digit1 = 4'd1; digit2 = 4'd2; digit3 = 4'd9;
        spin_start();
        wait_rv(20, n);
        chk("lose_latency", n, 6);
        chk("lose_lose", lose, 1);
        chk("lose_win", win, 0);
        chk("lose_payout", payout, 0);
        chk("lose_credits", credits, 3);
        tick();
        chk("lose_credits_after", credits, 3);

        // Drain remaining credits with losing spins
        for (int i = 0; i < 3; i++) begin
            spin_start();
            wait_rv(20, n);
            chk("drain_latency", n, 6);
            tick();
        end
        chk("drain_credits", credits, 0);

        // Start with no credits is ignored
        seen_busy = 1'b0;
        seen_rv   = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy) seen_busy = 1'b1;
            if (result_valid) seen_rv = 1'b1;
        end
        start = 1'b0;
        chk("nocredit_busy", seen_busy, 0);
        chk("nocredit_rv", seen_rv, 0);
        chk("nocredit_credits", credits, 0);

        apply_reset();
        chk("rst2_credits", credits, 2);

        // digit2 wraps through 10 before settling at 4
        digit1 = 4'd6; digit2 = 4'd9; digit3 = 4'd6;
        spin_start();
        seen_rv = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                digit2 = (k == 0) ? 4'd9 : ((k == 1) ? 4'd10 : 4'd0);
                tick();
                if (result_valid) seen_rv = 1'b1;
            end
        end
        chk("wrap_no_early_rv", seen_rv, 0);
        digit2 = 4'd4;
        wait_rv(20, n);
        chk("wrap_latency", n, 7);
        chk("wrap_win", win, 1);
        chk("wrap_payout", payout, 1);
        chk("wrap_credits", credits, 2);
        tick();

        // Reset mid-SPIN
        digit1 = 4'd7; digit2 = 4'd7; digit3 = 4'd7;
        spin_start();
        chk("midrst_credits_spent", credits, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_credits", credits, 2);
        chk("midrst_rv", result_valid, 0);
        seen_rv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result_valid) seen_rv = 1'b1;
        end
        chk("midrst_no_rv", seen_rv, 0);

        // digit1 never settles
        spin_start();
`ifdef REEL_JUDGE_TIMEOUT_EN
        n = 0;
        do begin
            digit1 = (digit1 == 4'd1) ? 4'd2 : 4'd1;
            tick();
            n++;
        end while (!result_valid && (n < 80));
        chk("to_latency", n, 40);
        chk("to_lose", lose, 1);
        chk("to_win", win, 0);
        chk("to_payout", payout, 0);
        chk("to_timeout", timeout, 1);
`else
        seen_rv   = 1'b0;
        seen_busy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            digit1 = (digit1 == 4'd1) ? 4'd2 : 4'd1;
            tick();
            if (result_valid) seen_rv = 1'b1;
            if (!busy) seen_busy = 1'b0;
        end
        chk("toggle_no_rv", seen_rv, 0);
        chk("toggle_busy", seen_busy, 1);
        chk("toggle_timeout", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
